hazard_ctrl_mc: RTL and testbench
=================================

Name: hazard_ctrl_mc

Overview:
- Next-generation hazard controller for the 5-stage RV32I pipeline. It supports a multi-cycle data memory through a ready handshake.
- Functions provided:
  - Same-cycle forwarding selects for the E stage.
  - Load-use stalls.
  - Branch/jump flushes.
  - A memory-wait FSM that freezes F/D/E/M and bubbles W.
  - A sticky memory-timeout error.
- Sits beside the datapath and control unit in the pipeline top. It replaces the single-cycle-memory hazard unit.

Parameters:
- REG_AW, 5, register-address width.
- TIMEOUT, 16, consecutive not-ready cycles that trigger the error (minimum 2).
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- Rs1D, Rs2D  in  REG_AW  decode-stage source registers
- Rs1E, Rs2E, RdE  in  REG_AW  execute-stage sources and destination
- RdM, RdW  in  REG_AW  memory/writeback destinations
- RegWriteM, RegWriteW  in  1  register-write enables for M and W
- ResultSrcE0  in  1  load is in E
- PCSrcE  in  1  branch taken or jump in E
- MemAccessM  in  1  load or store is in M
- MemReadyM  in  1  data memory completes the M access this cycle
- ForwardAE, ForwardBE  out  2  ALU operand selects: 00 register file, 01 W result, 10 M ALU result
- StallF, StallD, StallE, StallM  out  1  hold the stage register
- FlushD, FlushE, FlushW  out  1  bubble the stage register
- MemTimeout  out  1  sticky error
- WaitCnt  out  $clog2(TIMEOUT+1)  current consecutive not-ready count
- StallCycles  out  CNT_W  performance counter

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Outputs while reset is high:
  - all Stall* = 0;
  - FlushD = FlushE = FlushW = 1;
  - Forward* = 00.
- Registered values on the reset edge:
  - FSM → IDLE;
  - WaitCnt = 0;
  - MemTimeout = 0;
  - StallCycles = 0.
- Forwarding (combinational, zero latency), shown for operand A; operand B is identical using Rs2E:
  - 10 if RegWriteM && RdM != 0 && RdM == Rs1E;
  - else 01 if RegWriteW && RdW != 0 && RdW == Rs1E;
  - else 00.
  - M has priority over W.
- lwStall = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D).
- memStall = (state == ERR) || (MemAccessM && !MemReadyM).
- Output priority, highest first:
  1. memStall:
     - StallF = StallD = StallE = StallM = 1;
     - FlushW = 1;
     - FlushD = FlushE = 0 (PCSrcE is held in E and acted on after release).
  2. Otherwise:
     - StallF = StallD = lwStall;
     - StallE = StallM = 0;
     - FlushD = PCSrcE;
     - FlushE = lwStall || PCSrcE;
     - FlushW = 0.
  - lwStall together with PCSrcE: both apply. The flush wins on D, the stall holds F/D.
- Memory FSM, registered; states IDLE, WAIT, ERR:
  - IDLE:
    - if MemAccessM && !MemReadyM → WAIT, with WaitCnt = 1;
    - else stay, with WaitCnt = 0.
  - WAIT:
    - MemReadyM = 1 → IDLE, WaitCnt = 0;
    - else WaitCnt + 1; if that value equals TIMEOUT → ERR and MemTimeout = 1.
    - MemAccessM dropping while in WAIT is a protocol violation; it is treated as ready and returns to IDLE.
  - ERR:
    - pipeline frozen, WaitCnt holds TIMEOUT, MemTimeout stays 1;
    - exit only by reset.
- Boundaries:
  - Ready on the (TIMEOUT−1)-th not-ready cycle's successor means no error.
  - Ready and timeout in the same cycle: ready wins.
  - Reset mid-WAIT: returns to IDLE with no error.
  - Rd = x0 never forwards and never stalls.

Optional Feature:
- Macro HZ_PERF_CNT_EN.
- Defined: StallCycles increments by 1 on every cycle StallF = 1 outside reset, saturating at all-ones.
- Undefined: no counter register; StallCycles tied to 0.
- The port exists in both builds.

Decomposition:
- Package hazard_pkg contains:
  - enum fwd_sel_e: FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10;
  - enum mem_state_e: IDLE, WAIT, ERR;
  - the REG_AW default constant.
- Sub-module fwd_sel: comparator/priority logic for one operand, instantiated twice (A and B).
- FSM and stall logic stay in hazard_ctrl_mc.

Test Plan:
- Forwarding:
  - RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1, Rs1E = 5 → ForwardAE = 10.
  - RdM = 0 with Rs1E = 0 → 00.
  - RdW = 7, Rs2E = 7, RegWriteW = 1 → ForwardBE = 01.
- Load-use: ResultSrcE0 = 1, RdE = 3, Rs2D = 3 → StallF = StallD = FlushE = 1 for exactly one cycle, FlushD = 0.
- Branch: PCSrcE = 1 → FlushD = FlushE = 1, no stalls. Same with concurrent MemAccessM & !MemReadyM → stalls 1111, FlushW = 1, FlushD = FlushE = 0 until ready.
- Memory wait with TIMEOUT = 4: MemAccessM = 1, MemReadyM low 3 cycles then high:
  - WaitCnt goes 1, 2, 3, 0;
  - StallM high for 3 cycles;
  - MemTimeout stays 0.
- Timeout with TIMEOUT = 4: ready low 4 cycles → ERR after the 4th edge, MemTimeout = 1 and stalls held indefinitely. Assert reset for one cycle → IDLE, MemTimeout = 0, WaitCnt = 0.
- HZ_PERF_CNT_EN build: 2 load-use stalls + 3 memory-wait cycles → StallCycles = 5. Non-macro build → StallCycles = 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Purpose: shared types and defaults for the multi-cycle-memory hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: fwd_sel_e (ALU operand source), mem_state_e (memory-wait FSM), REG_AW default.
package hazard_pkg;

  localparam int REG_AW_DEFAULT = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR
  } mem_state_e;

endpackage

// File: rtl/hazard_ctrl_mc_fwd_sel.sv
// Purpose: forwarding source select for one E-stage ALU operand (M beats W, x0 never forwards).
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: rsE (operand source), rdM/rdW + regWriteM/regWriteW (producers), forward (select).
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              regWriteM,
  input  logic              regWriteW,
  output fwd_sel_e          forward
);

  logic hitM;
  logic hitW;

  assign hitM = regWriteM && (rdM != '0) && (rdM == rsE);
  assign hitW = regWriteW && (rdW != '0) && (rdW == rsE);

  // M holds the younger result, so it takes priority over W.
  always_comb begin
    forward = FWD_RF;
    if (hitM) begin
      forward = FWD_M;
    end else if (hitW) begin
      forward = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Purpose: RV32I 5-stage hazard control: forwarding, load-use stall, branch flush, memory-wait freeze.
// Latency: stall/flush/forward outputs are combinational; WaitCnt/MemTimeout/StallCycles are registered.
// Backpressure: MemReadyM low on an M access freezes F/D/E/M and bubbles W; timeout latches ERR until reset.
// Ports: Rs*/Rd*/RegWrite* (hazard sources), ResultSrcE0, PCSrcE, MemAccessM/MemReadyM (memory handshake),
//        Forward*E, Stall*, Flush*, MemTimeout, WaitCnt, StallCycles.
// Option: define HZ_PERF_CNT_EN to build the saturating StallF cycle counter; otherwise StallCycles reads 0.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEFAULT,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [REG_AW-1:0]            Rs1D,
  input  logic [REG_AW-1:0]            Rs2D,
  input  logic [REG_AW-1:0]            Rs1E,
  input  logic [REG_AW-1:0]            Rs2E,
  input  logic [REG_AW-1:0]            RdE,
  input  logic [REG_AW-1:0]            RdM,
  input  logic [REG_AW-1:0]            RdW,
  input  logic                         RegWriteM,
  input  logic                         RegWriteW,
  input  logic                         ResultSrcE0,
  input  logic                         PCSrcE,
  input  logic                         MemAccessM,
  input  logic                         MemReadyM,
  output logic [1:0]                   ForwardAE,
  output logic [1:0]                   ForwardBE,
  output logic                         StallF,
  output logic                         StallD,
  output logic                         StallE,
  output logic                         StallM,
  output logic                         FlushD,
  output logic                         FlushE,
  output logic                         FlushW,
  output logic                         MemTimeout,
  output logic [$clog2(TIMEOUT+1)-1:0] WaitCnt,
  output logic [CNT_W-1:0]             StallCycles
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] TIMEOUT_CNT = WCW'(TIMEOUT);

  fwd_sel_e   fwdA;
  fwd_sel_e   fwdB;
  mem_state_e memState;
  logic [WCW-1:0] waitCnt;
  logic [WCW-1:0] waitCntInc;
  logic           memTimeout;
  logic           lwStall;
  logic           memStall;

  fwd_sel #(.REG_AW(REG_AW)) uFwdA (
    .rsE(Rs1E), .rdM(RdM), .rdW(RdW),
    .regWriteM(RegWriteM), .regWriteW(RegWriteW), .forward(fwdA)
  );

  fwd_sel #(.REG_AW(REG_AW)) uFwdB (
    .rsE(Rs2E), .rdM(RdM), .rdW(RdW),
    .regWriteM(RegWriteM), .regWriteW(RegWriteW), .forward(fwdB)
  );

  assign ForwardAE = reset ? FWD_RF : fwdA;
  assign ForwardBE = reset ? FWD_RF : fwdB;

  assign lwStall  = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign memStall = (memState == ERR) || (MemAccessM && !MemReadyM);

  // A memory freeze outranks everything: the branch in E is held, not flushed,
  // and is acted on once the freeze releases.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (memStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lwStall;
      StallD = lwStall;
      FlushD = PCSrcE;
      FlushE = lwStall || PCSrcE;
    end
  end

  assign waitCntInc = waitCnt + WCW'(1);

  // Memory-wait FSM. Dropping MemAccessM mid-wait is treated as completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      memState   <= IDLE;
      waitCnt    <= '0;
      memTimeout <= 1'b0;
    end else begin
      case (memState)
        IDLE: begin
          if (MemAccessM && !MemReadyM) begin
            memState <= WAIT;
            waitCnt  <= WCW'(1);
          end else begin
            waitCnt  <= '0;
          end
        end
        WAIT: begin
          if (MemReadyM || !MemAccessM) begin
            memState <= IDLE;
            waitCnt  <= '0;
          end else begin
            waitCnt <= waitCntInc;
            if (waitCntInc == TIMEOUT_CNT) begin
              memState   <= ERR;
              memTimeout <= 1'b1;
            end
          end
        end
        ERR: begin
          waitCnt    <= TIMEOUT_CNT;
          memTimeout <= 1'b1;
        end
        default: begin
          memState <= IDLE;
          waitCnt  <= '0;
        end
      endcase
    end
  end

  assign WaitCnt    = waitCnt;
  assign MemTimeout = memTimeout;

`ifdef HZ_PERF_CNT_EN
  logic [CNT_W-1:0] stallCycles;

  // Saturates rather than wraps so a long-running count never reads small.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCycles <= '0;
    end else if (StallF && (stallCycles != '1)) begin
      stallCycles <= stallCycles + CNT_W'(1);
    end
  end

  assign StallCycles = stallCycles;
`else
  assign StallCycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Purpose: directed self-checking bench for hazard_ctrl_mc with TIMEOUT = 4.
// Latency: n/a.
// Backpressure: n/a.
module tb_hazard_ctrl_mc;

`ifdef HZ_PERF_CNT_EN
  localparam int PERF_EXP = 5;
`else
  localparam int PERF_EXP = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemAccessM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW;
  logic       MemTimeout;
  logic [2:0] WaitCnt;
  logic [31:0] StallCycles;

  int checks = 0;
  int errors = 0;

  hazard_ctrl_mc #(.REG_AW(5), .TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemTimeout(MemTimeout), .WaitCnt(WaitCnt), .StallCycles(StallCycles)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0;
    MemAccessM = 0; MemReadyM = 0;
  endtask

  initial begin
    clearInputs();
    reset = 1'b1;
    // Forwarding match present during reset must still read 00.
    RegWriteM = 1; RdM = 5; Rs1E = 5;
    tick();
    checkEq("rst_stalls", {28'd0, StallF, StallD, StallE, StallM}, 32'h0);
    checkEq("rst_flushes", {29'd0, FlushD, FlushE, FlushW}, 32'h7);
    checkEq("rst_fwdA", {30'd0, ForwardAE}, 32'h0);
    checkEq("rst_waitcnt", {29'd0, WaitCnt}, 32'h0);
    checkEq("rst_timeout", {31'd0, MemTimeout}, 32'h0);
    checkEq("rst_perf", StallCycles, 32'h0);
    reset = 1'b0;
    clearInputs();
    #1;
    checkEq("idle_flushes", {29'd0, FlushD, FlushE, FlushW}, 32'h0);

    // Forwarding
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; #1;
    checkEq("fwdA_M_over_W", {30'd0, ForwardAE}, 32'h2);
    RegWriteM = 0; #1;
    checkEq("fwdA_W", {30'd0, ForwardAE}, 32'h1);
    RegWriteM = 1; RdM = 0; Rs1E = 0; #1;
    checkEq("fwdA_x0", {30'd0, ForwardAE}, 32'h0);
    clearInputs();
    RdW = 7; Rs2E = 7; RegWriteW = 1; #1;
    checkEq("fwdB_W", {30'd0, ForwardBE}, 32'h1);
    checkEq("fwdA_none", {30'd0, ForwardAE}, 32'h0);
    RegWriteW = 0; #1;
    checkEq("fwdB_nowrite", {30'd0, ForwardBE}, 32'h0);
    clearInputs();

    // Load-use
    ResultSrcE0 = 1; RdE = 3; Rs2D = 3; #1;
    checkEq("lu_stall", {28'd0, StallF, StallD, StallE, StallM}, 32'hC);
    checkEq("lu_flush", {29'd0, FlushD, FlushE, FlushW}, 32'h2);
    tick();
    ResultSrcE0 = 0; RdE = 0; #1;  // load has moved on; bubble now in E
    checkEq("lu_release", {28'd0, StallF, StallD, FlushE, 1'b0}, 32'h0);
    ResultSrcE0 = 1; RdE = 0; Rs1D = 0; #1;
    checkEq("lu_x0", {31'd0, StallF}, 32'h0);
    clearInputs();

    // Branch, then branch under memory wait
    PCSrcE = 1; #1;
    checkEq("br_flush", {29'd0, FlushD, FlushE, FlushW}, 32'h6);
    checkEq("br_nostall", {28'd0, StallF, StallD, StallE, StallM}, 32'h0);
    MemAccessM = 1; MemReadyM = 0; #1;
    checkEq("brmem_stall", {28'd0, StallF, StallD, StallE, StallM}, 32'hF);
    checkEq("brmem_flush", {29'd0, FlushD, FlushE, FlushW}, 32'h1);
    tick();
    checkEq("brmem_stall2", {28'd0, StallF, StallD, StallE, StallM}, 32'hF);
    checkEq("brmem_flush2", {29'd0, FlushD, FlushE, FlushW}, 32'h1);
    MemReadyM = 1; #1;
    checkEq("brmem_release", {29'd0, FlushD, FlushE, FlushW}, 32'h6);
    tick();
    checkEq("brmem_waitcnt", {29'd0, WaitCnt}, 32'h0);
    clearInputs();

    // Memory wait: 3 not-ready cycles then ready (ready at TIMEOUT-1 wins)
    MemAccessM = 1; MemReadyM = 0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      checkEq($sformatf("mw_stallM_%0d", i), {31'd0, StallM}, 32'h1);
      tick();
      checkEq($sformatf("mw_cnt_%0d", i), {29'd0, WaitCnt}, i);
    end
    MemReadyM = 1; #1;
    checkEq("mw_stallM_rel", {31'd0, StallM}, 32'h0);
    tick();
    checkEq("mw_cnt_done", {29'd0, WaitCnt}, 32'h0);
    checkEq("mw_notimeout", {31'd0, MemTimeout}, 32'h0);

    // MemAccessM dropped mid-wait returns to idle
    MemReadyM = 0; tick();
    checkEq("drop_cnt1", {29'd0, WaitCnt}, 32'h1);
    MemAccessM = 0; tick();
    checkEq("drop_idle", {29'd0, WaitCnt}, 32'h0);

    // Timeout: 4 not-ready cycles
    MemAccessM = 1; MemReadyM = 0;
    for (int i = 1; i <= 3; i++) tick();
    checkEq("to_pre", {31'd0, MemTimeout}, 32'h0);
    tick();
    checkEq("to_err", {31'd0, MemTimeout}, 32'h1);
    checkEq("to_cnt", {29'd0, WaitCnt}, 32'h4);
    MemReadyM = 1; MemAccessM = 0;
    tick(); tick();
    checkEq("to_held_stall", {28'd0, StallF, StallD, StallE, StallM}, 32'hF);
    checkEq("to_held_flushW", {31'd0, FlushW}, 32'h1);
    checkEq("to_held_cnt", {29'd0, WaitCnt}, 32'h4);
    checkEq("to_sticky", {31'd0, MemTimeout}, 32'h1);
    reset = 1; tick();
    reset = 0; #1;
    checkEq("to_rst_timeout", {31'd0, MemTimeout}, 32'h0);
    checkEq("to_rst_cnt", {29'd0, WaitCnt}, 32'h0);
    checkEq("to_rst_stall", {31'd0, StallF}, 32'h0);
    checkEq("to_rst_perf", StallCycles, 32'h0);
    clearInputs();

    // Perf counter: 2 load-use stall cycles + 3 memory-wait cycles
    ResultSrcE0 = 1; RdE = 9; Rs1D = 9;
    tick(); tick();
    clearInputs();
    MemAccessM = 1; MemReadyM = 0;
    tick(); tick(); tick();
    MemReadyM = 1;
    tick();
    clearInputs();
    tick();
    checkEq("perf_count", StallCycles, PERF_EXP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
